// File: rtl/fetch_align_ctrl_pkg.sv
// Shared definitions for the fetch/align front end: FSM encoding, PC steps
// and the RVC detector used on the queue head.
package fetch_align_ctrl_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_IDLE = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC_C = 32'd2;
  localparam logic [31:0] PC_INC_W = 32'd4;

  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_ctrl_hw_queue.sv
// Circular halfword FIFO: push 0-2, pop 0-2 per cycle, flush; exposes the
// two head entries and the occupancy.
module fetch_align_ctrl_hw_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  input  logic [1:0]               push_n,
  input  logic [15:0]              push_lo,
  input  logic [15:0]              push_hi,
  input  logic [1:0]               pop_n,
  output logic [15:0]              head0,
  output logic [15:0]              head1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    rd_d  = rd_q + AW'(pop_n);
    wr_d  = wr_q + AW'(push_n);
    cnt_d = cnt_q - CW'(pop_n) + CW'(push_n);
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (en) begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy alone
  // decides which entries are meaningful, so it can map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (en && !flush) begin
      if (push_n != 2'd0) mem_q[wr_q] <= push_lo;
      if (push_n == 2'd2) mem_q[wr_q + AW'(1)] <= push_hi;
    end
  end

  assign head0 = mem_q[rd_q];
  assign head1 = mem_q[rd_q + AW'(1)];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_align_ctrl.sv
// Fetch/align controller: requests aligned words from the I-cache, buffers
// halfwords and hands one RVC or 32-bit instruction per handshake to decode.
module fetch_align_ctrl
  import fetch_align_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QUEUE_HW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_addr,
  input  logic        ic_req_ready,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_data,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic        dec_is_c,
  output logic [31:0] dec_pc,
  input  logic        dec_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(QUEUE_HW) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic          drop_low_q, drop_low_d;
  logic          squash_q, squash_d;
  logic          req_en_q, req_en_d;

  logic [CW-1:0] q_count, cnt_after;
  logic [15:0]   q_head0, q_head1;
  logic [1:0]    push_n, pop_n;
  logic [15:0]   push_lo;
  logic          head_is_c, req_fire, resp_fire, free_ok, redir_squash;

  fetch_align_ctrl_hw_queue #(.DEPTH(QUEUE_HW)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .en      (rdy),
    .flush   (redirect_valid),
    .push_n  (push_n),
    .push_lo (push_lo),
    .push_hi (ic_resp_data[31:16]),
    .pop_n   (pop_n),
    .head0   (q_head0),
    .head1   (q_head1),
    .count   (q_count)
  );

  assign head_is_c = is_rvc(q_head0);
  assign dec_valid = (head_is_c && q_count != '0) || (!head_is_c && q_count >= CW'(2));
  // An empty queue presents all-zero instruction fields.
  assign dec_is_c  = head_is_c && q_count != '0;
  assign dec_inst  = (q_count == '0) ? 32'h0 :
                     head_is_c       ? {16'h0, q_head0} : {q_head1, q_head0};
  assign dec_pc    = head_pc_q;

  // Request is held off for the first enabled cycle after reset.
  assign ic_req_valid = req_en_q && state_q == S_REQ;
  assign ic_req_addr  = fetch_addr_q;
  assign req_fire     = ic_req_valid && ic_req_ready;
  assign resp_fire    = state_q == S_WAIT && ic_resp_valid;

  assign pop_n = !(dec_valid && dec_ready && !redirect_valid) ? 2'd0 :
                 head_is_c ? 2'd1 : 2'd2;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    head_pc_d    = head_pc_q;
    drop_low_d   = drop_low_q;
    squash_d     = squash_q;
    req_en_d     = 1'b1;
    push_n       = 2'd0;
    push_lo      = drop_low_q ? ic_resp_data[31:16] : ic_resp_data[15:0];
    redir_squash = (state_q == S_WAIT && !ic_resp_valid) || req_fire;

    if (pop_n == 2'd1)      head_pc_d = head_pc_q + PC_INC_C;
    else if (pop_n == 2'd2) head_pc_d = head_pc_q + PC_INC_W;

    if (resp_fire && !squash_q && !redirect_valid) begin
      push_n       = drop_low_q ? 2'd1 : 2'd2;
      fetch_addr_d = fetch_addr_q + PC_INC_W;
      drop_low_d   = 1'b0;
    end

    cnt_after = q_count - CW'(pop_n) + CW'(push_n);
    free_ok   = cnt_after <= CW'(QUEUE_HW - 2);

    unique case (state_q)
      S_REQ:   if (req_fire) state_d = S_WAIT;
      S_WAIT:  if (ic_resp_valid) begin
                 squash_d = 1'b0;
                 state_d  = free_ok ? S_REQ : S_IDLE;
               end
      S_IDLE:  if (free_ok) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    // A redirect overrides consume and push; an outstanding request that has
    // not returned yet is marked for squashing.
    if (redirect_valid) begin
      head_pc_d    = redirect_pc & 32'hFFFF_FFFE;
      fetch_addr_d = redirect_pc & 32'hFFFF_FFFC;
      drop_low_d   = redirect_pc[1];
      squash_d     = redir_squash;
      state_d      = redir_squash ? S_WAIT : S_REQ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      fetch_addr_q <= RESET_PC & 32'hFFFF_FFFC;
      head_pc_q    <= RESET_PC;
      drop_low_q   <= RESET_PC[1];
      squash_q     <= 1'b0;
      req_en_q     <= 1'b0;
    end else if (rdy) begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      head_pc_q    <= head_pc_d;
      drop_low_q   <= drop_low_d;
      squash_q     <= squash_d;
      req_en_q     <= req_en_d;
    end
  end

endmodule

// File: doc/fetch_align_ctrl.md
Name: fetch_align_ctrl

Overview:
- Front-end controller that sequences the compressed-capable decoder.
- Fetches 32-bit aligned words from the instruction cache and buffers them as halfwords.
- Presents one aligned instruction (16-bit RVC or 32-bit) per handshake to the decoder, with its PC.
- Handles redirects from the decoder or ROB: in-flight responses are squashed and fetch restarts at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset.
- QUEUE_HW, 4, depth of the halfword queue; must be ≥4 and a power of two.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- rdy  in  1  global enable; when low, all state holds.
- ic_req_valid  out  1  word fetch request, held until accepted.
- ic_req_addr  out  32  word address; bits [1:0] are always 0.
- ic_req_ready  in  1  cache accepts the request this cycle.
- ic_resp_valid  in  1  response word valid; one cycle pulse.
- ic_resp_data  in  32  response word, little-endian halfwords.
- dec_valid  out  1  an instruction is available for the decoder.
- dec_inst  out  32  instruction; RVC is zero-extended in bits [15:0].
- dec_is_c  out  1  instruction is 16-bit (dec_inst[1:0] != 2'b11).
- dec_pc  out  32  PC of dec_inst.
- dec_ready  in  1  decoder accepts this cycle; driven low by its consumer when ROB, RS or LSB is full.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new PC; halfword aligned, bit 0 is ignored.

Behaviour:
- Reset (async, rst=1):
  - fetch_addr = RESET_PC & ~3; head_pc = RESET_PC.
  - Queue count = 0; drop_low = RESET_PC[1].
  - squash = 0; state = S_REQ.
  - Outputs: ic_req_valid=0, dec_valid=0, dec_inst=0, dec_is_c=0, dec_pc=RESET_PC.
  - ic_req_valid rises at the earliest one cycle after rst falls.
- Freeze: with rdy=0, no register updates; handshakes are ignored.
- FSM states: S_REQ, S_WAIT, S_IDLE.
  - S_REQ: ic_req_valid=1, ic_req_addr=fetch_addr. On ic_req_ready go to S_WAIT.
  - S_WAIT: await ic_resp_valid.
    - On response with squash=0: push halfwords into the queue (low first, skipping low if drop_low, then clear drop_low); fetch_addr += 4.
    - On response with squash=1: discard it and clear squash.
    - Next state is S_REQ if free slots ≥ 2 after this cycle's pop/push, else S_IDLE.
  - S_IDLE: go to S_REQ once free slots ≥ 2.
- Only one request is outstanding at a time. The cache returns the response ≥1 cycle after acceptance.
- Output (combinational from queue head):
  - dec_is_c = (q[0][1:0] != 2'b11).
  - dec_valid = (count ≥ 1 && dec_is_c) || (count ≥ 2 && !dec_is_c).
  - dec_inst = dec_is_c ? {16'b0, q[0]} : {q[1], q[0]}.
- Consume: on dec_valid && dec_ready && !redirect_valid, pop 1 (RVC) or 2 halfwords; head_pc += 2 or 4.
- Simultaneous pop and push in one cycle is legal. Count never exceeds QUEUE_HW, guaranteed by the ≥2-free rule.
- Redirect (highest priority over consume and push):
  - Queue count = 0; head_pc = {redirect_pc[31:1], 1'b0}.
  - fetch_addr = redirect_pc & ~3; drop_low = redirect_pc[1].
  - If state is S_WAIT, or S_REQ with ic_req_ready this cycle, set squash=1 and the next state is S_WAIT. Otherwise the next state is S_REQ.
  - A response arriving in the same cycle as a redirect is discarded. If that response completes the outstanding request, squash is not set.
  - dec_valid = 0 in the cycle after a redirect.
- Boundaries:
  - 32-bit instruction straddling a word: its upper halfword waits for the next response; dec_valid stays 0 until count ≥ 2.
  - fetch_addr and head_pc wrap modulo 2^32.
  - Async reset mid-request abandons the request; the cache must tolerate an unanswered request.

Decomposition:
- Shared const header: RVC detect macro (`is_rvc`), PC increment constants (2/4), and FSM state encodings.
- One natural sub-module: hw_queue.
  - Parameterised circular halfword FIFO with push of 1–2 entries, pop of 1–2 entries, and flush.
  - Exposes head two entries and count.

Test Plan:
- Reset with RESET_PC=0; ic returns 32'h0001_4505 (c.li a0,1 ; c.nop) → dec_inst=16'h4505, dec_pc=0, dec_is_c=1; next dec_pc=2, inst=16'h0001.
- Word 32'h00a0_0513 (addi a0,x0,10) at 0 → single dec_valid with dec_inst=32'h00a00513, dec_pc=0, dec_is_c=0.
- Straddle: word0 = {16'h0513, 16'h4505}, word1 = {16'h0001, 16'h00a0} → RVC at pc 0; 32'h00a00513 at pc 2, held until word1 arrives; RVC 16'h0001 at pc 6.
- dec_ready=0 for 10 cycles with continuous responses → count saturates at 4; ic_req_valid stays 0 while free slots < 2; no halfword is lost after dec_ready returns.
- redirect_pc=32'h0000_0102 while in S_WAIT → stale response dropped; next request addr 0x100; low halfword discarded; first dec_pc=0x102.
- redirect_valid asserted together with dec_ready and dec_valid → no pop; the next delivered dec_pc equals redirect_pc.
